// File: rtl/serial_sub4bits_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub4bits_pkg
//
// Purpose:
//   Shared definitions for the bit-serial signed subtractor. These include the
//   controller state encoding, the default operand width and the width of the
//   bit counter that walks through the operand.
//
// Contents:
//   DEF_WIDTH  - default operand/result width (4, matching the parallel lab adder)
//   CNT_W      - counter width able to hold 0..DEF_WIDTH
//   state_t    - controller states IDLE / SHIFT / DONE
//   cnt_width  - helper giving the counter width for an arbitrary WIDTH
// -----------------------------------------------------------------------------
package serial_sub4bits_pkg;

    localparam int DEF_WIDTH = 4;

    localparam int CNT_W = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter width for a non-default WIDTH; must cover the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub4bits_if.sv
// -----------------------------------------------------------------------------
// serial_sub4bits_if
//
// Purpose:
//   Handshake and operand/result bundle of the bit-serial subtractor.
//   The requester (master) presents start/x/y. The subtractor (slave) answers
//   with busy/done and the held result d/ov.
//
// Signals:
//   start - request, only honoured while the subtractor is idle
//   x     - signed minuend, captured on an accepted start
//   y     - signed subtrahend, captured on an accepted start
//   busy  - operation in progress (SHIFT or DONE)
//   done  - one-cycle pulse, d/ov freshly valid
//   d     - signed difference, held between operations
//   ov    - signed overflow of the last operation, held with d
// -----------------------------------------------------------------------------
interface serial_sub4bits_if
    import serial_sub4bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic                    start;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] d;
    logic                    ov;

    // Requester side: drives the operation request and operands.
    modport master (
        output start,
        output x,
        output y,
        input  busy,
        input  done,
        input  d,
        input  ov
    );

    // Subtractor side: consumes the request, produces status and result.
    modport slave (
        input  start,
        input  x,
        input  y,
        output busy,
        output done,
        output d,
        output ov
    );

endinterface

// File: rtl/serial_sub4bits_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Purpose:
//   The standard 1-bit full-adder cell of the add/sub lab. The bit-serial
//   subtractor uses one instance as its entire arithmetic datapath.
//
// Ports:
//   Cin  - carry in
//   X, Y - operand bits
//   S    - sum bit
//   Cout - carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic Cin,
    input  logic X,
    input  logic Y,
    output logic S,
    output logic Cout
);

    logic half_sum;

    // Classic two-half-adder form; half_sum is shared by the sum and carry terms.
    always_comb begin
        half_sum = X ^ Y;
        S        = half_sum ^ Cin;
        Cout     = (X & Y) | (Cin & half_sum);
    end

endmodule

// File: rtl/serial_sub4bits.sv
// -----------------------------------------------------------------------------
// serial_sub4bits
//
// Purpose:
//   Bit-serial signed subtractor computing d = x - y as x + ~y + 1. It uses a
//   single full-adder cell and processes one bit per clock, LSB first. A
//   start/busy/done handshake sequences an operation, which takes WIDTH+1
//   cycles from the accepted start to the done pulse. The result and its
//   overflow flag are held until the next operation completes.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset; aborts any operation in flight
//   bus  - serial_sub4bits_if slave modport (start, x, y, busy, done, d, ov)
// -----------------------------------------------------------------------------
module serial_sub4bits
    import serial_sub4bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_sub4bits_if.slave     bus
);

    // The package constant covers the default width; other widths derive it.
    localparam int NW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_width(WIDTH);

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  xs;
    logic [WIDTH-1:0]  ys;
    logic [WIDTH-1:0]  r;
    logic [NW-1:0]     n;
    logic              c;
    logic              cin_msb;
    logic              c_out;
    logic [WIDTH-1:0]  d_reg;
    logic              ov_reg;

    logic              accept;
    logic              shift_en;
    logic              last_bit;
    logic              busy_int;
    logic              done_int;
    logic              sum;
    logic              cout;
    logic              cin_msb_nx;
    logic              c_out_nx;
    logic              ov_nx;
    logic [WIDTH-1:0]  r_nx;

    // Single arithmetic cell. The LSBs of the shifting operand registers are
    // combined with the running carry.
    full_adder alu (
        .Cin  (c),
        .X    (xs[0]),
        .Y    (ys[0]),
        .S    (sum),
        .Cout (cout)
    );

    // The counter value equal to WIDTH-1 marks the MSB pass. That pass decides
    // the overflow and closes the operation.
    assign last_bit = (n == NW'(WIDTH - 1));

    // Result register after this cycle's sum bit enters from the MSB side. After
    // WIDTH shifts, the LSB produced first has reached bit 0.
    assign r_nx = {sum, r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    // A start outside IDLE is simply not looked at, so nothing is queued.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift_en   = 1'b0;
        busy_int   = 1'b0;
        done_int   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy_int = 1'b1;
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_int   = 1'b1;
                done_int   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // MSB carry bookkeeping.
    // Signed overflow is carry-into-MSB XOR carry-out-of-MSB. On the MSB pass
    // both carries are live this cycle, so ov is formed from the values being
    // recorded rather than waiting a cycle for the flops.
    always_comb begin
        cin_msb_nx = cin_msb;
        c_out_nx   = c_out;
        if (shift_en && last_bit) begin
            cin_msb_nx = c;
            c_out_nx   = cout;
        end
        ov_nx = cin_msb_nx ^ c_out_nx;
    end

    // Datapath registers.
    // On accept, ~y together with an initial carry of 1 turns the adder into a
    // subtractor. This also covers y = -2^(WIDTH-1) with no special case.
    // d/ov load only at the end of the MSB pass, so they hold the previous
    // result throughout an operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            xs      <= '0;
            ys      <= '0;
            r       <= '0;
            n       <= '0;
            c       <= 1'b0;
            cin_msb <= 1'b0;
            c_out   <= 1'b0;
            d_reg   <= '0;
            ov_reg  <= 1'b0;
        end else if (accept) begin
            xs <= bus.x;
            ys <= ~bus.y;
            c  <= 1'b1;
            n  <= '0;
        end else if (shift_en) begin
            r       <= r_nx;
            xs      <= {1'b0, xs[WIDTH-1:1]};
            ys      <= {1'b0, ys[WIDTH-1:1]};
            c       <= cout;
            n       <= n + 1'b1;
            cin_msb <= cin_msb_nx;
            c_out   <= c_out_nx;
            if (last_bit) begin
                d_reg  <= r_nx;
                ov_reg <= ov_nx;
            end
        end
    end

    assign bus.busy = busy_int;
    assign bus.done = done_int;
    assign bus.d    = d_reg;
    assign bus.ov   = ov_reg;

endmodule

// File: tb/tb_serial_sub4bits.sv
// -----------------------------------------------------------------------------
// tb_serial_sub4bits
//
// Purpose:
//   Self-checking bench for serial_sub4bits. Expected {ov, d} values come from
//   an integer reference model. They are queued when an operation is started
//   and popped when the DUT pulses done. Outputs are sampled on the falling
//   edge.
// -----------------------------------------------------------------------------
module tb_serial_sub4bits;
    import serial_sub4bits_pkg::*;

    localparam int W     = DEF_WIDTH;
    localparam int LIMIT = 20;

    logic clk = 1'b0;
    logic rst;

    serial_sub4bits_if #(.WIDTH(W)) bus ();

    serial_sub4bits #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         assert_count = 0;
    int         fail_count   = 0;
    int         done_count   = 0;
    int         accept_count = 0;
    logic [W:0] exp_q[$];
    logic [W:0] prev_res;

    // Independent tally of done pulses, later compared with accepted starts.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_count++;
        end
    end

    // Reference: true signed difference, wrapped result plus range check.
    function automatic logic [W:0] ref_sub(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
        int         diff;
        logic [W-1:0] dd;
        logic       ovf;
        diff = int'(a) - int'(b);
        dd   = diff[W-1:0];
        ovf  = (diff > (2 ** (W - 1)) - 1) || (diff < -(2 ** (W - 1)));
        return {ovf, dd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Checks made in the cycle where done is high: pop one expectation.
    task automatic check_output();
        logic [W:0] expv;
        expv = '1;
        check("busy_in_done", {31'd0, bus.busy}, 32'd1);
        check("sb_depth", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
        end
        check("result", {27'd0, bus.ov, bus.d}, {27'd0, expv});
        prev_res = expv;
    endtask

    // From an idle cycle, present operands with start high and queue the result.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_done", {31'd0, bus.done}, 32'd0);
        bus.x     = a;
        bus.y     = b;
        bus.start = 1'b1;
        exp_q.push_back(ref_sub(a, b));
        accept_count++;
    endtask

    // Wait (bounded) for done, checking busy and the held result meanwhile.
    // Latency is counted in falling edges from the edge that set up the request.
    task automatic wait_done(input bit drop, input int idle_lead, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (drop) begin
                bus.start = 1'b0;
            end
            if (bus.done !== 1'b1 && lat < LIMIT) begin
                if (lat > idle_lead) begin
                    check("busy_run", {31'd0, bus.busy}, 32'd1);
                end
                check("d_hold", {27'd0, bus.ov, bus.d}, {27'd0, prev_res});
            end
        end while (bus.done !== 1'b1 && lat < LIMIT);
        check("latency", lat, exp_lat);
        if (bus.done === 1'b1) begin
            check_output();
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        prev_res  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", {27'd0, bus.ov, bus.d}, 32'd0);
        rst = 1'b0;

        // Basic operation: 3 - 2.
        apply_stimulus(4'd3, 4'd2);
        wait_done(1'b1, 0, 5);

        // Overflow cases.
        apply_stimulus(4'sd8, 4'd1);     // -8 - 1
        wait_done(1'b1, 0, 5);
        apply_stimulus(4'd7, 4'hF);      // 7 - (-1)
        wait_done(1'b1, 0, 5);
        apply_stimulus(4'd0, 4'h8);      // 0 - (-8)
        wait_done(1'b1, 0, 5);

        // Non-overflow boundary cases.
        apply_stimulus(4'hD, 4'hD);      // -3 - (-3)
        wait_done(1'b1, 0, 5);
        apply_stimulus(4'hF, 4'd7);      // -1 - 7
        wait_done(1'b1, 0, 5);

        // Extra starts during SHIFT and DONE, with new operands, are ignored.
        apply_stimulus(4'd5, 4'd2);
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_busy1", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 4'h8;
        bus.y     = 4'd7;
        check("ign_busy2", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("ign_hold", {27'd0, bus.ov, bus.d}, {27'd0, prev_res});
        @(negedge clk);
        check("ign_done", {31'd0, bus.done}, 32'd1);
        if (bus.done === 1'b1) begin
            check_output();
        end
        bus.start = 1'b1;
        bus.x     = 4'd1;
        bus.y     = 4'd6;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("ign_idle_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("ign_still_idle", {31'd0, bus.busy}, 32'd0);
        check("ign_keep", {27'd0, bus.ov, bus.d}, {27'd0, prev_res});

        // start held high: one accept every WIDTH+2 cycles.
        apply_stimulus(4'd6, 4'd1);
        wait_done(1'b0, 0, 5);
        for (int k = 0; k < 3; k++) begin
            bus.x = 4'(k * 5 + 2);
            bus.y = 4'(9 - k * 3);
            exp_q.push_back(ref_sub(bus.x, bus.y));
            accept_count++;
            wait_done(1'b0, 1, 6);
        end
        bus.start = 1'b0;

        // Reset in the third SHIFT cycle aborts the operation and clears d/ov.
        apply_stimulus(4'd6, 4'd1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", {27'd0, bus.ov, bus.d}, 32'd0);
        exp_q.delete();
        accept_count--;
        prev_res = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, bus.done}, 32'd0);
        end
        apply_stimulus(4'hE, 4'd5);      // -2 - 5
        wait_done(1'b1, 0, 5);

        // Exhaustive sweep of all operand pairs.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                apply_stimulus(a[W-1:0], b[W-1:0]);
                wait_done(1'b1, 0, 5);
            end
        end

        @(negedge clk);
        check("done_per_start", done_count, accept_count);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
